// File: rtl/sat_arb.sv
`default_nettype none
// ============================================================================
// Module      : sat_arb
// Description : Two-requester round-robin arbiter feeding one saturating
//               signed add/subtract unit with a single-entry result register.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_s,
    output logic             resp_v,
    output logic [7:0]       sat_cnt
);

    localparam logic [WIDTH-1:0] c_max = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_min = {1'b1, {(WIDTH-1){1'b0}}};

    logic             r_last;
    logic             r_resp_valid;
    logic             r_resp_id;
    logic [WIDTH-1:0] r_resp_s;
    logic             r_resp_v;
    logic [7:0]       r_sat_cnt;

    logic             w_cap;
    logic             w_any;
    logic             w_gnt_id;
    logic             w_accept;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_sub;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_sat;

    assign w_cap    = !r_resp_valid || resp_ready;
    assign w_any    = req0_valid || req1_valid;
    // On contention the requester that lost the last accepted transfer wins.
    assign w_gnt_id = (req0_valid && req1_valid) ? !r_last : req1_valid;
    assign w_accept = !rst && w_cap && w_any;

    assign req0_ready = w_accept && !w_gnt_id;
    assign req1_ready = w_accept &&  w_gnt_id;

    assign w_a   = w_gnt_id ? req1_a   : req0_a;
    assign w_b   = w_gnt_id ? req1_b   : req0_b;
    assign w_sub = w_gnt_id ? req1_sub : req0_sub;

    // One extra bit holds the exact result; overflow shows as a sign mismatch.
    assign w_sum = w_sub ? ({w_a[WIDTH-1], w_a} - {w_b[WIDTH-1], w_b})
                         : ({w_a[WIDTH-1], w_a} + {w_b[WIDTH-1], w_b});
    assign w_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
    assign w_sat = !w_ovf ? w_sum[WIDTH-1:0] : (w_sum[WIDTH] ? c_min : c_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last       <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_s     <= '0;
            r_resp_v     <= 1'b0;
            r_sat_cnt    <= 8'd0;
        end else if (w_accept) begin
            r_last       <= w_gnt_id;
            r_resp_valid <= 1'b1;
            r_resp_id    <= w_gnt_id;
            r_resp_s     <= w_sat;
            r_resp_v     <= w_ovf;
            if (w_ovf && (r_sat_cnt != 8'hFF)) begin
                r_sat_cnt <= r_sat_cnt + 8'd1;
            end
        end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_s     = r_resp_s;
    assign resp_v     = r_resp_v;
    assign sat_cnt    = r_sat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sat_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_sat_arb
// Description : Directed vector bench for sat_arb (WIDTH = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sat_arb;

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [7:0]        req0_a, req0_b, req1_a, req1_b;
    logic              req0_sub, req1_sub;
    logic              resp_valid, resp_ready, resp_id, resp_v;
    logic signed [7:0] resp_s;
    logic [7:0]        sat_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sat_arb #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_s(resp_s), .resp_v(resp_v),
        .sat_cnt(sat_cnt)
    );

    typedef struct {
        logic        rst;
        logic        v0;
        logic [7:0]  a0;
        logic [7:0]  b0;
        logic        s0;
        logic        v1;
        logic [7:0]  a1;
        logic [7:0]  b1;
        logic        s1;
        logic        rr;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        e_valid;
        logic        chk;
        logic        e_id;
        logic [7:0]  e_s;
        logic        e_v;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input int idx, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, got, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst        = t.rst;
        req0_valid = t.v0; req0_a = t.a0; req0_b = t.b0; req0_sub = t.s0;
        req1_valid = t.v1; req1_a = t.a1; req1_b = t.b1; req1_sub = t.s1;
        resp_ready = t.rr;
    endtask

    initial begin
        //            rst v0 a0      b0      s0 v1 a1      b1      s1 rr  rdy0 rdy1 val chk id s       v  cnt
        vecs[0]  = '{1, 1, 8'd1,   8'd1,   0, 0, 8'd0,   8'd0,   0, 1,  0, 0, 0, 1, 0, 8'd0,   0, 8'd0};
        vecs[1]  = '{0, 1, 8'd100, 8'd50,  0, 0, 8'd0,   8'd0,   0, 1,  1, 0, 1, 1, 0, 8'd127, 1, 8'd1};
        vecs[2]  = '{0, 0, 8'd0,   8'd0,   0, 1, -8'sd100, 8'd100, 1, 1, 0, 1, 1, 1, 1, 8'h80,  1, 8'd2};
        vecs[3]  = '{0, 0, 8'd0,   8'd0,   0, 1, 8'd0,   8'h80,  1, 1,  0, 1, 1, 1, 1, 8'd127, 1, 8'd3};
        vecs[4]  = '{0, 0, 8'd0,   8'd0,   0, 1, 8'd5,   -8'sd3, 1, 1,  0, 1, 1, 1, 1, 8'd8,   0, 8'd3};
        vecs[5]  = '{0, 1, 8'd1,   8'd2,   0, 1, 8'd10,  8'd4,   1, 1,  1, 0, 1, 1, 0, 8'd3,   0, 8'd3};
        vecs[6]  = '{0, 1, 8'd1,   8'd2,   0, 1, 8'd10,  8'd4,   1, 1,  0, 1, 1, 1, 1, 8'd6,   0, 8'd3};
        vecs[7]  = '{0, 1, 8'd1,   8'd2,   0, 1, 8'd10,  8'd4,   1, 1,  1, 0, 1, 1, 0, 8'd3,   0, 8'd3};
        vecs[8]  = '{0, 1, 8'd1,   8'd2,   0, 1, 8'd10,  8'd4,   1, 1,  0, 1, 1, 1, 1, 8'd6,   0, 8'd3};
        vecs[9]  = '{0, 1, -8'sd50, -8'sd100, 0, 0, 8'd0, 8'd0,  0, 0,  0, 0, 1, 1, 1, 8'd6,   0, 8'd3};
        vecs[10] = '{0, 1, -8'sd50, -8'sd100, 0, 0, 8'd0, 8'd0,  0, 0,  0, 0, 1, 1, 1, 8'd6,   0, 8'd3};
        vecs[11] = '{0, 1, -8'sd50, -8'sd100, 0, 0, 8'd0, 8'd0,  0, 0,  0, 0, 1, 1, 1, 8'd6,   0, 8'd3};
        vecs[12] = '{0, 1, -8'sd50, -8'sd100, 0, 0, 8'd0, 8'd0,  0, 1,  1, 0, 1, 1, 0, 8'h80,  1, 8'd4};
        vecs[13] = '{0, 0, 8'd0,   8'd0,   0, 0, 8'd0,   8'd0,   0, 1,  0, 0, 0, 0, 0, 8'd0,   0, 8'd4};
        vecs[14] = '{0, 1, 8'd1,   8'd1,   0, 0, 8'd0,   8'd0,   0, 1,  1, 0, 1, 1, 0, 8'd2,   0, 8'd4};
        vecs[15] = '{1, 1, 8'd100, 8'd100, 0, 0, 8'd0,   8'd0,   0, 1,  0, 0, 0, 1, 0, 8'd0,   0, 8'd0};
        vecs[16] = '{0, 1, 8'd1,   8'd2,   0, 1, 8'd10,  8'd4,   1, 0,  1, 0, 1, 1, 0, 8'd3,   0, 8'd0};
        vecs[17] = '{0, 1, 8'd1,   8'd2,   0, 1, 8'd10,  8'd4,   1, 0,  0, 0, 1, 1, 0, 8'd3,   0, 8'd0};
        vecs[18] = '{0, 1, 8'd1,   8'd2,   0, 1, 8'd10,  8'd4,   1, 1,  0, 1, 1, 1, 1, 8'd6,   0, 8'd0};

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i]);
            #1;
            check("req0_ready", i, int'(req0_ready), int'(vecs[i].e_rdy0));
            check("req1_ready", i, int'(req1_ready), int'(vecs[i].e_rdy1));
            @(posedge clk);
            #1;
            check("resp_valid", i, int'(resp_valid), int'(vecs[i].e_valid));
            check("sat_cnt", i, int'(sat_cnt), int'(vecs[i].e_cnt));
            if (vecs[i].chk) begin
                check("resp_id", i, int'(resp_id), int'(vecs[i].e_id));
                check("resp_s", i, int'(resp_s), int'($signed(vecs[i].e_s)));
                check("resp_v", i, int'(resp_v), int'(vecs[i].e_v));
            end
        end

        // Saturating counter: 260 back-to-back overflowing adds from requester 0.
        rst = 1'b0;
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 8'd100; req0_b = 8'd100; req0_sub = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            #1;
            check("sat_ready", i, int'(req0_ready), 1);
            @(posedge clk);
            #1;
            check("sat_cnt_run", i, int'(sat_cnt), (i + 1 > 255) ? 255 : i + 1);
            if (i == 259) begin
                check("sat_valid", i, int'(resp_valid), 1);
                check("sat_s", i, int'(resp_s), 127);
                check("sat_v", i, int'(resp_v), 1);
            end
        end

        // Reset with a result pending and requester 0 handshaking clears everything.
        rst = 1'b1;
        #1;
        check("rst_ready0", 0, int'(req0_ready), 0);
        @(posedge clk);
        #1;
        check("rst_valid", 0, int'(resp_valid), 0);
        check("rst_cnt", 0, int'(sat_cnt), 0);
        check("rst_s", 0, int'(resp_s), 0);
        rst = 1'b0;
        req0_valid = 1'b0;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        check("idle_valid", 0, int'(resp_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
